yadan_test_monitor: RTL and testbench
=====================================

// Module: yadan_test_monitor
// PURPOSE
//  Synthesizable, parametrised test-completion monitor for yadan SoC regression runs. Replaces fixed
//  done/pass register probes, fixed settle delay and fixed timeout with NUM_CH independent channels.
//  Each channel has done/pass/info inputs. Adds a cycle watchdog, first-failure capture and restart.
//  Sits beside yadan_riscv_sopc; benches and FPGA builds observe its outputs.
// PARAMETERS
//  NUM_CH       1      number of monitored channels (>=1)
//  DATA_W       32     width of per-channel info word (failing-test index)
//  SETTLE_CYC   5      cycles from all-done to pass sampling (>=1)
//  TIMEOUT_CYC  50000  RUN cycles before timeout (>=2)
//  CNT_W        32     width of cycle counter (2^CNT_W > TIMEOUT_CYC)
// PORTS
//  clk          in   1               system clock
//  rst          in   1               asynchronous, active-low reset
//  clear_i      in   1               synchronous restart pulse
//  done_i       in   NUM_CH          per-channel test-finished level
//  pass_i       in   NUM_CH          per-channel pass level, valid once done
//  info_i       in   NUM_CH*DATA_W   per-channel info; channel c at [c*DATA_W +: DATA_W]
//  busy_o       out  1               state is RUN or SETTLE
//  done_o       out  1               terminal state reached (PASS, FAIL or TIMEOUT)
//  pass_o       out  1               state is PASS
//  timeout_o    out  1               state is TIMEOUT
//  done_mask_o  out  NUM_CH          sticky per-channel done flags
//  fail_ch_o    out  $clog2(NUM_CH)+1  lowest failing channel index; all-ones if none
//  fail_info_o  out  DATA_W          info_i of fail_ch_o, sampled at pass sampling
//  cycle_cnt_o  out  CNT_W           RUN cycles elapsed, frozen outside RUN
// BEHAVIOUR
//  Reset (rst=0, async): state RUN, busy_o=1, all other outputs 0.
//    Exception: fail_ch_o resets to all-ones. Counters and mask clear.
//  All outputs are registered; there is no combinational input-to-output path.
//  States: RUN, SETTLE, PASS, FAIL, TIMEOUT.
//  RUN:
//    - done_mask |= done_i every cycle; cycle_cnt increments.
//    - If (done_mask|done_i) is all-ones, go to SETTLE with settle_cnt=0.
//    - Else if cycle_cnt==TIMEOUT_CYC-1, go to TIMEOUT.
//    - All-done in the same cycle as terminal count: done wins, next state is SETTLE.
//  SETTLE:
//    - settle_cnt increments; cycle_cnt and done_mask are frozen.
//    - done_i deassertion is ignored (mask is sticky).
//    - At the edge where settle_cnt==SETTLE_CYC-1, sample pass_i and info_i.
//      If all pass, go to PASS. Otherwise go to FAIL, load fail_ch_o with the
//      lowest c where pass_i[c]=0, and load fail_info_o with info_i of channel c.
//    - Latency: done_o rises SETTLE_CYC cycles after the edge that first sees all-done.
//  PASS / FAIL / TIMEOUT:
//    - Hold all outputs; inputs are ignored.
//    - On TIMEOUT, fail_ch_o and fail_info_o keep reset values; done_mask_o shows progress.
//  clear_i=1 (any state): next edge enters RUN.
//    Counters, mask and fail capture return to reset values. clear_i has priority over all transitions.
//  Reset mid-SETTLE or mid-RUN: immediate return to reset values; no partial result is retained.
//  cycle_cnt saturates; it never wraps because the timeout fires first.
// TESTING
//  T1 NUM_CH=1, SETTLE_CYC=5: done_i=1 at cycle 10 with pass_i=1
//     -> done_o=1 and pass_o=1 five cycles later; cycle_cnt_o=11.
//  T2 NUM_CH=1: done_i=1, pass_i=0, info_i=32'h17
//     -> FAIL; pass_o=0, fail_ch_o=0, fail_info_o=32'h17.
//  T3 NUM_CH=4: done pulses on ch3,0,2,1 at cycles 5,9,12,20; pass_i=4'b1001 at sampling
//     -> done_mask_o=4'hF; FAIL with fail_ch_o=1; done_o at cycle 25.
//  T4 TIMEOUT_CYC=100, done_i=0
//     -> timeout_o=1 and done_o=1 after 100 RUN cycles; cycle_cnt_o=99; done_mask_o=0.
//  T5 TIMEOUT_CYC=100: all done on the terminal-count cycle
//     -> SETTLE then PASS; timeout_o never asserts.
//  T6 rst=0 during SETTLE, then release; later clear_i in PASS
//     -> outputs return to reset values, busy_o=1, cycle_cnt_o restarts from 0.

Source files
------------

// File: rtl/yadan_test_monitor.sv
// Test-completion monitor for yadan SoC regression runs.
// Watches NUM_CH independent done/pass/info channels, waits a settle window
// after every channel has finished, then reports pass, first failure, or a
// cycle-watchdog timeout. clear_i restarts the monitor from any state.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear_i       synchronous restart pulse (highest priority)
//   done_i        per-channel test-finished level
//   pass_i        per-channel pass level, valid once done
//   info_i        per-channel info word, channel c at [c*DATA_W +: DATA_W]
//   busy_o        RUN or SETTLE
//   done_o        PASS, FAIL or TIMEOUT reached
//   pass_o        PASS reached
//   timeout_o     TIMEOUT reached
//   done_mask_o   sticky per-channel done flags
//   fail_ch_o     lowest failing channel, all-ones if none
//   fail_info_o   info word of fail_ch_o captured at pass sampling
//   cycle_cnt_o   RUN cycles elapsed, frozen outside RUN
module yadan_test_monitor #(
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SETTLE_CYC  = 5,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic [NUM_CH-1:0]          done_i,
    input  logic [NUM_CH-1:0]          pass_i,
    input  logic [NUM_CH*DATA_W-1:0]   info_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       timeout_o,
    output logic [NUM_CH-1:0]          done_mask_o,
    output logic [$clog2(NUM_CH):0]    fail_ch_o,
    output logic [DATA_W-1:0]          fail_info_o,
    output logic [CNT_W-1:0]           cycle_cnt_o
);

    localparam int unsigned FCH_W = $clog2(NUM_CH) + 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYC) + 1;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [SET_W-1:0]   settle_q,    settle_d;
    logic [NUM_CH-1:0]  mask_q,      mask_d;
    logic [FCH_W-1:0]   fail_ch_q,   fail_ch_d;
    logic [DATA_W-1:0]  fail_info_q, fail_info_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               pass_q,      pass_d;
    logic               timeout_q,   timeout_d;

    logic               all_done;
    logic               all_pass;
    logic               terminal;
    logic               settle_end;
    logic [FCH_W-1:0]   low_ch;
    logic [DATA_W-1:0]  low_info;

    // Lowest channel with pass_i low, and its info word.
    always_comb begin
        low_ch   = '1;
        low_info = '0;
        for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
            if (!pass_i[c]) begin
                low_ch   = FCH_W'(c);
                low_info = info_i[c*DATA_W +: DATA_W];
            end
        end
    end

    assign all_done   = &(mask_q | done_i);
    assign all_pass   = &pass_i;
    assign terminal   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign settle_end = (settle_q == SET_W'(SETTLE_CYC - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        mask_d      = mask_q;
        fail_ch_d   = fail_ch_q;
        fail_info_d = fail_info_q;

        if (clear_i) begin
            state_d     = ST_RUN;
            cnt_d       = '0;
            settle_d    = '0;
            mask_d      = '0;
            fail_ch_d   = '1;
            fail_info_d = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    mask_d = mask_q | done_i;
                    // All-done beats the watchdog on the terminal-count cycle.
                    if (all_done) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end else if (terminal) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_end) begin
                        if (all_pass) begin
                            state_d = ST_PASS;
                        end else begin
                            state_d     = ST_FAIL;
                            fail_ch_d   = low_ch;
                            fail_info_d = low_info;
                        end
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d    = (state_d == ST_RUN) || (state_d == ST_SETTLE);
        done_d    = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
        pass_d    = (state_d == ST_PASS);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            settle_q    <= '0;
            mask_q      <= '0;
            fail_ch_q   <= '1;
            fail_info_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            mask_q      <= mask_d;
            fail_ch_q   <= fail_ch_d;
            fail_info_q <= fail_info_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign done_mask_o = mask_q;
    assign fail_ch_o   = fail_ch_q;
    assign fail_info_o = fail_info_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_yadan_test_monitor.sv
// Scoreboard bench for yadan_test_monitor: random done/pass/info episodes,
// expected outcome computed from the channel rules and queued; a monitor
// pops and compares whenever done_o rises and checks the hold afterwards.
module tb_yadan_test_monitor;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned SC  = 5;
    localparam int unsigned TO  = 100;
    localparam int unsigned CW  = 32;
    localparam int unsigned FCW = 3;
    localparam int          L   = 128;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clear_i = 1'b0;
    logic [NCH-1:0]      done_i = '0;
    logic [NCH-1:0]      pass_i = '0;
    logic [NCH*DW-1:0]   info_i = '0;
    logic                busy_o, done_o, pass_o, timeout_o;
    logic [NCH-1:0]      done_mask_o;
    logic [FCW-1:0]      fail_ch_o;
    logic [DW-1:0]       fail_info_o;
    logic [CW-1:0]       cycle_cnt_o;

    yadan_test_monitor #(
        .NUM_CH(NCH), .DATA_W(DW), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .done_i(done_i), .pass_i(pass_i), .info_i(info_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .done_mask_o(done_mask_o), .fail_ch_o(fail_ch_o),
        .fail_info_o(fail_info_o), .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk = ~clk;

    // kind: 0 pass, 1 fail, 2 timeout
    typedef struct {
        int             kind;
        logic [FCW-1:0] fch;
        logic [DW-1:0]  finfo;
        logic [CW-1:0]  cnt;
        logic [NCH-1:0] mask;
        int             dk;
    } exp_t;

    exp_t              q[$];
    int                total = 0;
    int                bad   = 0;
    int                k_cur = -1;
    logic [NCH-1:0]    dv[L];
    logic [NCH-1:0]    pv[L];
    logic [NCH*DW-1:0] iv[L];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic rv_check(input string tag);
        chk({tag, "_busy"},    64'(busy_o),      64'd1);
        chk({tag, "_done"},    64'(done_o),      64'd0);
        chk({tag, "_pass"},    64'(pass_o),      64'd0);
        chk({tag, "_timeout"}, 64'(timeout_o),   64'd0);
        chk({tag, "_mask"},    64'(done_mask_o), 64'd0);
        chk({tag, "_cnt"},     64'(cycle_cnt_o), 64'd0);
        chk({tag, "_fch"},     64'(fail_ch_o),   64'h7);
        chk({tag, "_finfo"},   64'(fail_info_o), 64'd0);
    endtask

    // Stimulus tables plus expected outcome from the channel rules.
    // mode 0 random, 1 one channel never done, 2 last channel done on the
    // terminal-count cycle, 3 forced all-pass, 4 early all-done.
    function automatic exp_t build(input int mode);
        exp_t           e;
        int             tc[NCH];
        logic [NCH-1:0] quiet;
        logic [NCH-1:0] acc;
        int             t;
        int             m;
        quiet = '0;
        m = int'($urandom_range(0, NCH - 1));
        for (int c = 0; c < NCH; c++) begin
            if (mode == 4) tc[c] = int'($urandom_range(0, 3));
            else           tc[c] = int'($urandom_range(0, 90));
        end
        if (mode == 1) begin tc[m] = -1;            quiet[m] = 1'b1; end
        if (mode == 2) begin tc[m] = int'(TO) - 1;  quiet[m] = 1'b1; end
        for (int k = 0; k < L; k++) begin
            dv[k] = '0;
            for (int c = 0; c < NCH; c++) begin
                if (tc[c] == k || (!quiet[c] && $urandom_range(0, 15) == 0)) dv[k][c] = 1'b1;
                pv[k][c] = (mode == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            iv[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        acc = '0;
        t = -1;
        for (int k = 0; k < int'(TO); k++) begin
            acc |= dv[k];
            if (acc == '1) begin t = k; break; end
        end
        e.fch   = '1;
        e.finfo = '0;
        if (t >= 0) begin
            int sk = t + int'(SC);
            e.dk   = sk;
            e.cnt  = CW'(t + 1);
            e.mask = '1;
            e.kind = (pv[sk] == '1) ? 0 : 1;
            for (int c = NCH - 1; c >= 0; c--) begin
                if (!pv[sk][c]) begin
                    e.fch   = FCW'(c);
                    e.finfo = iv[sk][c*DW +: DW];
                end
            end
        end else begin
            e.kind = 2;
            e.dk   = int'(TO) - 1;
            e.cnt  = CW'(TO - 1);
            e.mask = acc;
        end
        return e;
    endfunction

    // Monitor: compare on done_o rise, then check the terminal hold.
    exp_t cur;
    bit   seen = 0;
    bit   have = 0;
    always @(posedge clk) begin
        #1;
        if (rst && done_o) begin
            if (!seen) begin
                seen = 1;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    have = 0;
                    $display("FAIL spurious_done: got done_o=1 want no pending result");
                end else begin
                    cur  = q.pop_front();
                    have = 1;
                    chk("done_edge", 64'(k_cur),       64'(cur.dk));
                    chk("pass_o",    64'(pass_o),      64'(cur.kind == 0));
                    chk("timeout_o", 64'(timeout_o),   64'(cur.kind == 2));
                    chk("busy_o",    64'(busy_o),      64'd0);
                    chk("fail_ch",   64'(fail_ch_o),   64'(cur.fch));
                    chk("fail_info", 64'(fail_info_o), 64'(cur.finfo));
                    chk("cycle_cnt", 64'(cycle_cnt_o), 64'(cur.cnt));
                    chk("done_mask", 64'(done_mask_o), 64'(cur.mask));
                end
            end else if (have) begin
                chk("hold_cnt",  64'(cycle_cnt_o), 64'(cur.cnt));
                chk("hold_info", 64'(fail_info_o), 64'(cur.finfo));
                chk("hold_mask", 64'(done_mask_o), 64'(cur.mask));
                chk("hold_pass", 64'(pass_o),      64'(cur.kind == 0));
            end
        end else begin
            seen = 0;
            have = 0;
        end
    end

    task automatic start_clear();
        @(negedge clk);
        clear_i = 1'b1;
        done_i  = NCH'($urandom);
        pass_i  = NCH'($urandom);
        info_i  = {$urandom, $urandom, $urandom, $urandom};
        k_cur   = -1;
    endtask

    task automatic episode(input int mode);
        exp_t e;
        e = build(mode);
        q.push_back(e);
        start_clear();
        for (int k = 0; k <= e.dk + 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                clear_i = 1'b0;
                rv_check("clear");
            end
            done_i = dv[k];
            pass_i = pv[k];
            info_i = iv[k];
            k_cur  = k;
        end
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL no_done: got %0d pending results want 0", q.size());
            q.delete();
        end
    endtask

    // Reset asserted while settling: nothing retained, counter restarts.
    task automatic reset_mid_settle();
        exp_t e;
        e = build(4);
        start_clear();
        for (int k = 0; k <= e.dk - 3; k++) begin
            @(negedge clk);
            clear_i = 1'b0;
            done_i  = dv[k];
            pass_i  = pv[k];
            info_i  = iv[k];
            k_cur   = k;
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1 rv_check("rst_settle");
        @(negedge clk);
        rst    = 1'b1;
        done_i = '0;
        k_cur  = -1;
        repeat (3) @(negedge clk);
        chk("restart_cnt",  64'(cycle_cnt_o), 64'd3);
        chk("restart_busy", 64'(busy_o),      64'd1);
        chk("restart_mask", 64'(done_mask_o), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rv_check("reset");
        rst = 1'b1;
        episode(0);
        episode(1);
        episode(2);
        episode(3);
        episode(4);
        reset_mid_settle();
        episode(3);
        for (int i = 0; i < 24; i++) episode(int'($urandom_range(0, 4)));
        reset_mid_settle();
        episode(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
